bmem_arbiter: RTL and testbench
===============================

// Module: bmem_arbiter
// PURPOSE
//  Shares the single burst-memory port between the L1 I-cache and L1 D-cache miss paths.
//  Requesters see a whole-line interface. The arbiter serialises and deserialises 64-bit bursts.
//  Sits between the cache hierarchy and burst_memory, inside mp4.
// PARAMETERS
//  CACHE_LOG2_WORDSIZE  10  log2 of line width in bits (>=7); LINE_W=2**N, BEATS=2**(N-6)
//  ADDR_W               32  byte-address width
// PORTS
//  clk            in   1       clock
//  rst            in   1       asynchronous, active-high reset
//  i_addr         in   ADDR_W  I-side line address
//  i_read         in   1       I-side line read request; held until i_resp
//  i_rdata        out  LINE_W  read line, valid when i_resp=1
//  i_resp         out  1       one-cycle completion pulse
//  d_addr         in   ADDR_W  D-side line address
//  d_read         in   1       D-side read request; held until d_resp
//  d_write        in   1       D-side write-back request; held until d_resp
//  d_wdata        in   LINE_W  write-back line
//  d_rdata        out  LINE_W  read line, valid when d_resp=1
//  d_resp         out  1       one-cycle completion pulse
//  bmem_address   out  ADDR_W  line-aligned address (low N-3 bits forced 0)
//  bmem_read      out  1       read command, one-cycle pulse
//  bmem_write     out  1       write beat valid
//  bmem_wdata     out  64      write beat
//  bmem_rdata     in   64      read beat
//  bmem_resp      in   1       read: per-beat valid; write: one-cycle completion pulse
// BEHAVIOUR
//  - Reset (async): state=IDLE. bmem_read=bmem_write=0, bmem_address=0, bmem_wdata=0,
//    i_resp=d_resp=0, line buffer=0, beat count=0, last_grant=D (the I-side wins first).
//  - States: IDLE, RD_CMD, RD_BEATS, WR_BEATS, WR_WAIT, DONE.
//  - IDLE: on any request, grant the requester. If both request, grant the one not in last_grant (round-robin).
//    On grant, latch address and owner. For writes, latch d_wdata into the line buffer.
//    Read grant -> RD_CMD. Write grant -> WR_BEATS.
//  - RD_CMD: bmem_read=1 for exactly one cycle with the address -> RD_BEATS.
//  - RD_BEATS: each bmem_resp=1 cycle stores bmem_rdata at beat index cnt (beat 0 = bits [63:0]) and increments cnt.
//    Gaps between beats are legal. The beat with cnt==BEATS-1 -> DONE.
//  - WR_BEATS: bmem_write=1 for BEATS consecutive cycles, presenting beat cnt (low beat first).
//    Address is held stable throughout. After the last beat -> WR_WAIT.
//  - WR_WAIT: bmem_write=0; wait for bmem_resp -> DONE. A bmem_resp arriving during WR_BEATS is ignored.
//  - DONE: assert the owner's resp for one cycle. i_rdata/d_rdata both drive the line buffer.
//    Update last_grant. -> IDLE. The next grant is never earlier than the cycle after DONE.
//  - Latency, read, no contention: request seen in IDLE at cycle 0; bmem_read at cycle 1; resp 1 cycle after the last beat.
//  - d_read && d_write both high: write wins; flagged by an assertion (illegal).
//  - Requests deasserted before resp: undefined; the transaction still completes.
//  - Reset mid-burst: immediate IDLE, outputs to reset values; the partial line is discarded.
//  - Beat counter width: N-6 bits; wraps to 0 on the last beat.
// CONFIGURATION
//  BMEM_ARB_PERF_EN defined: adds 32-bit saturating counters, readable hierarchically by the bench:
//  - perf_i_reads: I-side grants
//  - perf_d_reads: D-side read grants
//  - perf_d_writes: D-side write grants
//  - perf_conflict: IDLE cycles with both sides requesting
//  - perf_busy: cycles not in IDLE
//  All counters are zeroed on rst.
//  BMEM_ARB_PERF_EN undefined: no counters and no extra logic; port list is identical either way.
// STRUCTURE
//  - bmem_arb_pkg:
//    - state enum bmem_arb_state_t
//    - owner enum {OWN_I, OWN_D}
//    - localparam BEAT_W=64
//    - functions beats(n), line_align(addr,n)
//  - Sub-module rr_grant2: 2-way round-robin picker (req[1:0], last -> grant).
//    Combinational, instanced once.
//  - Line buffer and counter live in the top module.
// TESTING
//  1. Single I read at 0x4000_0044 -> bmem_address=0x4000_0000, one bmem_read pulse; 16 beats 0..15 return;
//     i_rdata[64k+:64]=k; i_resp is 1 cycle; d_resp stays 0.
//  2. D write-back of 0x6000_0080, line beat k=0xA5A5_0000_0000_0000+k -> 16 consecutive bmem_write cycles in order;
//     d_resp exactly 1 cycle after the bmem_resp pulse.
//  3. i_read and d_read both raised in the same cycle after reset -> I served first, then D.
//     Both held continuously -> grants alternate I,D,I,D over 4 transactions.
//  4. Read beats with random 0-5 cycle gaps -> line assembles correctly; no early resp.
//  5. rst asserted at beat 7 of a read -> outputs 0 asynchronously (before the next edge).
//     After release, a new D read completes with correct data.
//  6. With BMEM_ARB_PERF_EN, run scenario 3 -> perf_i_reads=2, perf_d_reads=2, perf_conflict>=1.

Source files
------------

// File: rtl/bmem_arb_pkg.sv
// Shared types and helpers for the burst-memory arbiter.
package bmem_arb_pkg;

   localparam int unsigned BEAT_W = 64;

   typedef enum logic [2:0] {
      StIdle,
      StRdCmd,
      StRdBeats,
      StWrBeats,
      StWrWait,
      StDone
   } bmem_arb_state_t;

   typedef enum logic {OWN_I, OWN_D} owner_t;

   function automatic int unsigned beats(input int unsigned n);
      return 32'd1 << (n - 6);
   endfunction

   function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned n);
      return addr & ~((64'd1 << (n - 3)) - 64'd1);
   endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin picker: on contention the side that did not win last time is granted.
module rr_grant2
   import bmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  owner_t     last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (req[0] && (!req[1] || last == OWN_D)) begin
         grant = 2'b01;
      end else if (req[1]) begin
         grant = 2'b10;
      end
   end

endmodule

// File: rtl/bmem_arbiter.sv
// Shares one 64-bit burst-memory port between the I-cache and D-cache line interfaces.
// Optional BMEM_ARB_PERF_EN adds saturating performance counters (no port change).
module bmem_arbiter
   import bmem_arb_pkg::*;
#(
   parameter int unsigned CACHE_LOG2_WORDSIZE = 10,
   parameter int unsigned ADDR_W              = 32,
   localparam int unsigned LINE_W             = 2 ** CACHE_LOG2_WORDSIZE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic [ADDR_W-1:0] bmem_address,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [BEAT_W-1:0] bmem_wdata,
   input  logic [BEAT_W-1:0] bmem_rdata,
   input  logic              bmem_resp
);

   localparam int unsigned CNT_W = CACHE_LOG2_WORDSIZE - 6;
   localparam int unsigned BEATS = beats(CACHE_LOG2_WORDSIZE);

   bmem_arb_state_t   state_q;
   owner_t            owner_q;
   owner_t            last_grant_q;
   logic [LINE_W-1:0] line_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        grant;

   rr_grant2 u_rr_grant2 (
      .req   ({d_read | d_write, i_read}),
      .last  (last_grant_q),
      .grant (grant)
   );

   assign i_rdata = line_q;
   assign d_rdata = line_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         owner_q      <= OWN_I;
         last_grant_q <= OWN_D;
         line_q       <= '0;
         cnt_q        <= '0;
         bmem_read    <= 1'b0;
         bmem_write   <= 1'b0;
         bmem_address <= '0;
         bmem_wdata   <= '0;
         i_resp       <= 1'b0;
         d_resp       <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant[0]) begin
                  owner_q      <= OWN_I;
                  bmem_address <= ADDR_W'(line_align(64'(i_addr), CACHE_LOG2_WORDSIZE));
                  bmem_read    <= 1'b1;
                  cnt_q        <= '0;
                  state_q      <= StRdCmd;
               end else if (grant[1]) begin
                  owner_q      <= OWN_D;
                  bmem_address <= ADDR_W'(line_align(64'(d_addr), CACHE_LOG2_WORDSIZE));
                  if (d_write) begin
                     // Beat 0 goes out with the grant; cnt_q tracks the next beat to present.
                     line_q     <= d_wdata;
                     bmem_write <= 1'b1;
                     bmem_wdata <= d_wdata[BEAT_W-1:0];
                     cnt_q      <= CNT_W'(1);
                     state_q    <= StWrBeats;
                  end else begin
                     bmem_read <= 1'b1;
                     cnt_q     <= '0;
                     state_q   <= StRdCmd;
                  end
               end
            end
            StRdCmd: begin
               bmem_read <= 1'b0;
               state_q   <= StRdBeats;
            end
            StRdBeats: begin
               if (bmem_resp) begin
                  line_q[cnt_q*BEAT_W +: BEAT_W] <= bmem_rdata;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(BEATS - 1)) begin
                     state_q <= StDone;
                     if (owner_q == OWN_I) i_resp <= 1'b1;
                     else                  d_resp <= 1'b1;
                  end
               end
            end
            StWrBeats: begin
               // cnt_q has wrapped to zero while the last beat is on the bus.
               if (cnt_q == '0) begin
                  bmem_write <= 1'b0;
                  bmem_wdata <= '0;
                  state_q    <= StWrWait;
               end else begin
                  bmem_wdata <= line_q[cnt_q*BEAT_W +: BEAT_W];
                  cnt_q      <= cnt_q + CNT_W'(1);
               end
            end
            StWrWait: begin
               if (bmem_resp) begin
                  d_resp  <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDone: begin
               i_resp       <= 1'b0;
               d_resp       <= 1'b0;
               last_grant_q <= owner_q;
               state_q      <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Simultaneous D read and write is a requester bug; the write is served.
   assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

`ifdef BMEM_ARB_PERF_EN
   logic [31:0] perf_i_reads;
   logic [31:0] perf_d_reads;
   logic [31:0] perf_d_writes;
   logic [31:0] perf_conflict;
   logic [31:0] perf_busy;
   logic        idle;

   assign idle = (state_q == StIdle);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_i_reads  <= '0;
         perf_d_reads  <= '0;
         perf_d_writes <= '0;
         perf_conflict <= '0;
         perf_busy     <= '0;
      end else begin
         if (idle && grant[0] && perf_i_reads != '1) perf_i_reads <= perf_i_reads + 32'd1;
         if (idle && grant[1] && !d_write && perf_d_reads != '1) begin
            perf_d_reads <= perf_d_reads + 32'd1;
         end
         if (idle && grant[1] && d_write && perf_d_writes != '1) begin
            perf_d_writes <= perf_d_writes + 32'd1;
         end
         if (idle && i_read && (d_read || d_write) && perf_conflict != '1) begin
            perf_conflict <= perf_conflict + 32'd1;
         end
         if (!idle && perf_busy != '1) perf_busy <= perf_busy + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bmem_arbiter.sv
// Randomised self-checking bench for bmem_arbiter; acts as both caches and the burst memory.
module tb_bmem_arbiter;

   localparam int unsigned N          = 10;
   localparam int unsigned LINE_W     = 2 ** N;
   localparam int          BEATS      = 2 ** (N - 6);
   localparam int unsigned LINE_BYTES = LINE_W / 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       i_addr, d_addr, bmem_address;
   logic              i_read, i_resp, d_read, d_write, d_resp;
   logic [LINE_W-1:0] i_rdata, d_rdata, d_wdata;
   logic              bmem_read, bmem_write, bmem_resp;
   logic [63:0]       bmem_wdata, bmem_rdata;

   int vectors = 0;
   int errors  = 0;

   bmem_arbiter #(
      .CACHE_LOG2_WORDSIZE (N),
      .ADDR_W              (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_addr       (i_addr),
      .i_read       (i_read),
      .i_rdata      (i_rdata),
      .i_resp       (i_resp),
      .d_addr       (d_addr),
      .d_read       (d_read),
      .d_write      (d_write),
      .d_wdata      (d_wdata),
      .d_rdata      (d_rdata),
      .d_resp       (d_resp),
      .bmem_address (bmem_address),
      .bmem_read    (bmem_read),
      .bmem_write   (bmem_write),
      .bmem_wdata   (bmem_wdata),
      .bmem_rdata   (bmem_rdata),
      .bmem_resp    (bmem_resp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_align(input logic [31:0] a);
      return a - (a % LINE_BYTES);
   endfunction

   // Caller has already raised the request; memory side returns a line with random gaps.
   task automatic serve_read(input bit side_d, input logic [31:0] addr, input int gapmax,
                             input bit count_data, input bit drop);
      logic [63:0] bq [BEATS];
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!bmem_read && n < 50);
      check("rd_cmd_latency", 64'(n), 64'd1);
      if (!bmem_read) return;
      check("rd_addr", 64'(bmem_address), 64'(exp_align(addr)));
      step();
      check("rd_cmd_pulse", 64'(bmem_read), 64'd0);
      for (int k = 0; k < BEATS; k++) begin
         int g;
         g = $urandom_range(gapmax, 0);
         repeat (g) begin
            step();
            check("no_early_resp", 64'({i_resp, d_resp}), 64'd0);
         end
         bq[k] = count_data ? 64'(k) : {$urandom, $urandom};
         bmem_rdata = bq[k];
         bmem_resp  = 1'b1;
         step();
         bmem_resp  = 1'b0;
         bmem_rdata = '0;
         if (k != BEATS - 1) check("no_early_resp", 64'({i_resp, d_resp}), 64'd0);
      end
      check("i_resp", 64'(i_resp), 64'(!side_d));
      check("d_resp", 64'(d_resp), 64'(side_d));
      for (int k = 0; k < BEATS; k++) begin
         check(side_d ? "d_rdata_beat" : "i_rdata_beat",
               side_d ? d_rdata[k*64 +: 64] : i_rdata[k*64 +: 64], bq[k]);
      end
      if (drop) begin
         if (side_d) d_read = 1'b0;
         else        i_read = 1'b0;
      end
      step();
      check("resp_one_cycle", 64'({i_resp, d_resp}), 64'd0);
   endtask

   task automatic serve_write(input logic [31:0] addr, input bit pattern);
      logic [63:0] wl [BEATS];
      int n, spur, g;
      for (int k = 0; k < BEATS; k++) begin
         wl[k] = pattern ? 64'hA5A5_0000_0000_0000 + 64'(k) : {$urandom, $urandom};
         d_wdata[k*64 +: 64] = wl[k];
      end
      d_addr  = addr;
      d_write = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!bmem_write && n < 50);
      check("wr_latency", 64'(n), 64'd1);
      if (!bmem_write) return;
      spur = $urandom_range(BEATS - 1, 0);
      for (int k = 0; k < BEATS; k++) begin
         check("wr_valid", 64'(bmem_write), 64'd1);
         check("wr_beat", bmem_wdata, wl[k]);
         check("wr_addr", 64'(bmem_address), 64'(exp_align(addr)));
         bmem_resp = (k == spur);
         step();
         bmem_resp = 1'b0;
      end
      check("wr_valid_end", 64'(bmem_write), 64'd0);
      g = $urandom_range(3, 0);
      repeat (g) begin
         check("wr_no_early_resp", 64'(d_resp), 64'd0);
         step();
      end
      check("wr_no_early_resp", 64'(d_resp), 64'd0);
      bmem_resp = 1'b1;
      step();
      bmem_resp = 1'b0;
      check("wr_d_resp", 64'(d_resp), 64'd1);
      check("wr_i_resp", 64'(i_resp), 64'd0);
      d_write = 1'b0;
      step();
      check("wr_resp_one_cycle", 64'(d_resp), 64'd0);
   endtask

   initial begin
      logic [31:0] a;
      rst = 1'b1;
      i_addr = '0; i_read = 1'b0; d_addr = '0; d_read = 1'b0; d_write = 1'b0;
      d_wdata = '0; bmem_rdata = '0; bmem_resp = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("rst_bmem_read", 64'(bmem_read), 64'd0);
      check("rst_bmem_write", 64'(bmem_write), 64'd0);
      check("rst_bmem_address", 64'(bmem_address), 64'd0);
      check("rst_bmem_wdata", bmem_wdata, 64'd0);
      check("rst_resps", 64'({i_resp, d_resp}), 64'd0);
      check("rst_line", i_rdata[63:0], 64'd0);

      // Contention straight after reset: I first, then strict alternation.
      i_addr = 32'h1000_0040; d_addr = 32'h2000_0100;
      i_read = 1'b1;          d_read = 1'b1;
      serve_read(1'b0, i_addr, 2, 1'b0, 1'b0);
      serve_read(1'b1, d_addr, 2, 1'b0, 1'b0);
      serve_read(1'b0, i_addr, 2, 1'b0, 1'b1);
      serve_read(1'b1, d_addr, 2, 1'b0, 1'b1);
`ifdef BMEM_ARB_PERF_EN
      check("perf_i_reads", 64'(dut.perf_i_reads), 64'd2);
      check("perf_d_reads", 64'(dut.perf_d_reads), 64'd2);
      check("perf_conflict_nonzero", 64'(dut.perf_conflict != 0), 64'd1);
`endif

      i_addr = 32'h4000_0044;
      i_read = 1'b1;
      serve_read(1'b0, i_addr, 0, 1'b1, 1'b1);

      serve_write(32'h6000_0080, 1'b1);

      for (int t = 0; t < 3; t++) begin
         i_addr = $urandom;
         i_read = 1'b1;
         serve_read(1'b0, i_addr, 5, 1'b0, 1'b1);
      end

      // Reset at beat 7 of a read: outputs clear before the next edge.
      i_addr = $urandom | 32'h8000_0000;
      i_read = 1'b1;
      step();
      check("rst_mid_cmd", 64'(bmem_read), 64'd1);
      step();
      for (int k = 0; k < 7; k++) begin
         bmem_rdata = {$urandom, $urandom} | 64'd1;
         bmem_resp  = 1'b1;
         step();
      end
      bmem_resp = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_mid_address", 64'(bmem_address), 64'd0);
      check("rst_mid_line", i_rdata[63:0], 64'd0);
      check("rst_mid_resps", 64'({i_resp, d_resp, bmem_read, bmem_write}), 64'd0);
      i_read = 1'b0;
      step();
      rst = 1'b0;
      d_addr = $urandom;
      d_read = 1'b1;
      serve_read(1'b1, d_addr, 3, 1'b0, 1'b1);

      for (int t = 0; t < 8; t++) begin
         a = $urandom;
         case ($urandom_range(2, 0))
            0: begin
               i_addr = a;
               i_read = 1'b1;
               serve_read(1'b0, a, 5, 1'b0, 1'b1);
            end
            1: begin
               d_addr = a;
               d_read = 1'b1;
               serve_read(1'b1, a, 5, 1'b0, 1'b1);
            end
            default: serve_write(a, 1'b0);
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
